// File: rtl/psram_cmd_sequencer.sv
// Turns one block-transfer request into the MSB/CSB/LSB/INSTR register writes for the PSRAM
// controller, then clears INSTR and waits for the controller to report idle again.
module psram_cmd_sequencer #(
  parameter int unsigned MONARCH_DATA_WIDTH    = 8,
  parameter int unsigned MONARCH_ADDRESS_WIDTH = 2,
  parameter int unsigned PSRAM_ADDRESS_WIDTH   = 24,
  parameter int unsigned START_TIMEOUT         = 16
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             req_valid,
  output logic                             req_ready,
  input  logic [1:0]                       req_op,
  input  logic                             req_src_sd,
  input  logic                             req_dst_sd,
  input  logic [PSRAM_ADDRESS_WIDTH-1:0]   req_addr,
  output logic                             done,
  output logic                             err,
  output logic                             busy,
  output logic [MONARCH_DATA_WIDTH-1:0]    monarch_axi_tdata,
  output logic [MONARCH_ADDRESS_WIDTH-1:0] monarch_axi_taddress,
  output logic                             monarch_axi_tvalid,
  input  logic                             monarch_axi_tready
);

  localparam int unsigned DW   = MONARCH_DATA_WIDTH;
  localparam int unsigned CntW = (START_TIMEOUT > 1) ? $clog2(START_TIMEOUT) : 1;

  typedef enum logic [3:0] {
    StIdle, StWrMsb, StWrCsb, StWrLsb, StWrInstr, StWaitStart, StClear, StWaitDone, StDone
  } state_e;

  state_e                         state_q, state_d;
  logic [PSRAM_ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic [DW-1:0]                  instr_q, instr_d;
  logic                           err_q, err_d;
  logic [CntW-1:0]                cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      addr_q  <= '0;
      instr_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      instr_q <= instr_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d              = state_q;
    addr_d               = addr_q;
    instr_d              = instr_q;
    err_d                = err_q;
    cnt_d                = cnt_q;
    req_ready            = 1'b0;
    done                 = 1'b0;
    err                  = 1'b0;
    busy                 = 1'b1;
    monarch_axi_tvalid   = 1'b0;
    monarch_axi_tdata    = '0;
    monarch_axi_taddress = '0;

    unique case (state_q)
      StIdle: begin
        busy      = 1'b0;
        req_ready = ~reset;
        if (req_valid) begin
          addr_d  = req_addr;
          instr_d = {{(DW-4){1'b0}}, req_dst_sd, req_src_sd, req_op};
          // 00 and 11 are both illegal: report straight away without touching the bus
          err_d   = (req_op[1] == req_op[0]);
          cnt_d   = '0;
          state_d = (req_op[1] == req_op[0]) ? StDone : StWrMsb;
        end
      end
      StWrMsb: begin
        monarch_axi_tvalid   = 1'b1;
        monarch_axi_taddress = MONARCH_ADDRESS_WIDTH'(3);
        monarch_axi_tdata    = addr_q[3*DW-1:2*DW];
        if (monarch_axi_tready) state_d = StWrCsb;
      end
      StWrCsb: begin
        monarch_axi_tvalid   = 1'b1;
        monarch_axi_taddress = MONARCH_ADDRESS_WIDTH'(2);
        monarch_axi_tdata    = addr_q[2*DW-1:DW];
        if (monarch_axi_tready) state_d = StWrLsb;
      end
      StWrLsb: begin
        monarch_axi_tvalid   = 1'b1;
        monarch_axi_taddress = MONARCH_ADDRESS_WIDTH'(1);
        monarch_axi_tdata    = addr_q[DW-1:0];
        if (monarch_axi_tready) state_d = StWrInstr;
      end
      StWrInstr: begin
        monarch_axi_tvalid = 1'b1;
        monarch_axi_tdata  = instr_q;
        if (monarch_axi_tready) begin
          cnt_d   = '0;
          state_d = StWaitStart;
        end
      end
      StWaitStart: begin
        if (!monarch_axi_tready) begin
          state_d = StClear;
        end else if (cnt_q == CntW'(START_TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = StClear;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StClear: begin
        // Settings registers latch on tvalid alone, so this beat ignores tready
        monarch_axi_tvalid = 1'b1;
        state_d            = err_q ? StDone : StWaitDone;
      end
      StWaitDone: begin
        if (monarch_axi_tready) state_d = StDone;
      end
      StDone: begin
        done    = 1'b1;
        err     = err_q;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

endmodule

// File: tb/tb_psram_cmd_sequencer.sv
// Bench for psram_cmd_sequencer: directed scenarios plus random requests and controller
// handshakes, checked against an expected register-write list and completion rules.
module tb_psram_cmd_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic        req_src_sd;
  logic        req_dst_sd;
  logic [23:0] req_addr;
  logic        done;
  logic        err;
  logic        busy;
  logic [7:0]  tdata;
  logic [1:0]  taddress;
  logic        tvalid;
  logic        tready;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  psram_cmd_sequencer dut (
    .clk                  (clk),
    .reset                (reset),
    .req_valid            (req_valid),
    .req_ready            (req_ready),
    .req_op               (req_op),
    .req_src_sd           (req_src_sd),
    .req_dst_sd           (req_dst_sd),
    .req_addr             (req_addr),
    .done                 (done),
    .err                  (err),
    .busy                 (busy),
    .monarch_axi_tdata    (tdata),
    .monarch_axi_taddress (taddress),
    .monarch_axi_tvalid   (tvalid),
    .monarch_axi_tready   (tready)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Mode: 0 random handshake, 1 tready always high, 2 drop tready after 3 start cycles
  // and release 2 cycles into the wait, 3 stall CSB 5 cycles then drop tready at once.
  task automatic run_txn(input logic [1:0] op, input logic src, input logic dst,
                         input logic [23:0] addr, input int mode);
    logic [9:0] exp_q[$];
    logic [9:0] hold_v;
    logic [7:0] instr;
    logic       legal;
    int         idx, stall, cyc, hi_cnt, wd_cnt;
    bit         exp_clear, exp_done, timeout, hold, hold_hi, fin, trd;

    legal = (op == 2'b01) || (op == 2'b10);
    instr = {4'b0000, dst, src, op};
    exp_q = {};
    if (legal) begin
      exp_q.push_back({2'd3, addr[23:16]});
      exp_q.push_back({2'd2, addr[15:8]});
      exp_q.push_back({2'd1, addr[7:0]});
      exp_q.push_back({2'd0, instr});
      exp_q.push_back(10'd0);
    end
    idx = 0; stall = 0; cyc = 0; hi_cnt = 0; wd_cnt = 0;
    exp_clear = 0; timeout = 0; hold = 0; fin = 0; trd = 1;
    exp_done = !legal;
    hold_hi  = ($urandom_range(0, 3) == 0);
    hold_v   = '0;

    check("accept_ready", req_ready, 1);
    req_valid  = 1'b1;
    req_op     = op;
    req_src_sd = src;
    req_dst_sd = dst;
    req_addr   = addr;
    tready     = 1'b1;
    step();

    for (int c = 0; c < 300 && !fin; c++) begin
      cyc++;
      check("busy", busy, 1);
      check("ready_low", req_ready, 0);
      check("done", done, exp_done);
      if (done != exp_done) begin
        fin = 1;
      end else if (done) begin
        check("err", err, (!legal || timeout) ? 1 : 0);
        check("beats", idx, exp_q.size());
        fin = 1;
      end else begin
        if (hold) begin
          check("hold", {tvalid, taddress, tdata}, {1'b1, hold_v});
          hold = 0;
        end
        if (idx < 4) begin
          check("wr_tvalid", tvalid, 1);
          case (mode)
            0:       trd = ($urandom_range(0, 3) != 0);
            3:       trd = !(idx == 1 && stall < 5);
            default: trd = 1;
          endcase
          if (trd) begin
            check("wr_beat", {taddress, tdata}, exp_q[idx]);
            if (idx == 3) check("instr_time", cyc, 4 + stall);
            idx++;
          end else begin
            stall++;
            hold   = 1;
            hold_v = {taddress, tdata};
          end
        end else if (idx == 4) begin
          check("start_tvalid", tvalid, exp_clear);
          if (exp_clear) begin
            check("clear_beat", {taddress, tdata}, 10'd0);
            idx       = 5;
            exp_clear = 0;
            exp_done  = timeout;
            trd       = (mode == 0) ? ($urandom_range(0, 1) == 1) : 0;
          end else begin
            case (mode)
              0:       trd = hold_hi ? 1 : ($urandom_range(0, 1) == 1);
              2:       trd = (hi_cnt < 3);
              3:       trd = 0;
              default: trd = 1;
            endcase
            if (!trd) begin
              exp_clear = 1;
            end else begin
              hi_cnt++;
              if (hi_cnt == 16) begin
                timeout   = 1;
                exp_clear = 1;
              end
            end
          end
        end else begin
          check("wait_tvalid", tvalid, 0);
          case (mode)
            0:       trd = ($urandom_range(0, 2) == 0);
            2:       trd = (wd_cnt >= 2);
            default: trd = 1;
          endcase
          wd_cnt++;
          if (trd) exp_done = 1;
        end
      end
      if (!fin) begin
        tready     = trd;
        req_valid  = ($urandom_range(0, 1) == 1);
        req_op     = 2'($urandom);
        req_addr   = 24'($urandom);
        req_src_sd = ($urandom_range(0, 1) == 1);
        req_dst_sd = ($urandom_range(0, 1) == 1);
        step();
      end
    end
    check("txn_budget", fin, 1);
    req_valid = 1'b0;
    step();
    check("post_ready", req_ready, 1);
    check("post_busy", busy, 0);
    check("post_done", done, 0);
    check("post_tvalid", tvalid, 0);
  endtask

  initial begin
    reset      = 1'b1;
    req_valid  = 1'b0;
    req_op     = 2'b00;
    req_src_sd = 1'b0;
    req_dst_sd = 1'b0;
    req_addr   = '0;
    tready     = 1'b1;
    step();
    step();
    check("rst_ready", req_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_tvalid", tvalid, 0);
    check("rst_tdata", tdata, 0);
    check("rst_taddr", taddress, 0);
    reset = 1'b0;
    #1;
    check("rel_ready", req_ready, 1);

    run_txn(2'b01, 1'b0, 1'b1, 24'h123456, 1);
    run_txn(2'b01, 1'b0, 1'b1, 24'h123456, 2);
    run_txn(2'b10, 1'b1, 1'b0, 24'h123456, 3);
    run_txn(2'b11, 1'b0, 1'b0, 24'habcdef, 0);
    run_txn(2'b00, 1'b1, 1'b1, 24'h00ff00, 0);

    // Reset while waiting for the controller to finish
    req_valid = 1'b1;
    req_op    = 2'b01;
    req_addr  = 24'h5a5a5a;
    tready    = 1'b1;
    step();
    req_valid = 1'b0;
    step();
    step();
    step();
    step();
    tready = 1'b0;
    step();
    step();
    check("wd_tvalid", tvalid, 0);
    check("wd_busy", busy, 1);
    reset = 1'b1;
    #1;
    check("mid_rst_ready", req_ready, 0);
    step();
    check("mid_rst_tvalid", tvalid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    reset = 1'b0;
    #1;
    run_txn(2'b10, 1'b0, 1'b1, 24'h0badc0, 0);

    for (int n = 0; n < 40; n++) begin
      run_txn(2'($urandom_range(0, 3)), ($urandom_range(0, 1) == 1),
              ($urandom_range(0, 1) == 1), 24'($urandom), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
